// File: rtl/branch_flag_unit.sv
// rtl/branch_flag_unit.sv - Z/N/V flag register, conditional branch resolution and front-end flush
module branch_flag_unit #(
    parameter int FLUSH_CYCLES = 2,
    parameter int PC_W         = 16,
    parameter int FWD_FLAGS    = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            stall,
    input  logic            ex_valid,
    input  logic            ex_set_all,
    input  logic            ex_set_z,
    input  logic            alu_z,
    input  logic            alu_n,
    input  logic            alu_v,
    input  logic            br_valid,
    input  logic [2:0]      br_cond,
    input  logic [PC_W-1:0] br_target,
    output logic            z_flag,
    output logic            n_flag,
    output logic            v_flag,
    output logic            br_taken,
    output logic [PC_W-1:0] br_pc,
    output logic            flush
);

    localparam logic [0:0] S_IDLE   = 1'b0;
    localparam logic [0:0] S_FLUSH  = 1'b1;
    localparam logic [2:0] CNT_INIT = 3'(FLUSH_CYCLES - 1);
    localparam logic       FWD      = (FWD_FLAGS != 0);

    logic [0:0]      r_state;
    logic [2:0]      r_cnt;
    logic            r_z, r_n, r_v;
    logic            r_taken;
    logic [PC_W-1:0] r_pc;
    logic            r_flush;

    logic w_idle, w_wr_all, w_wr_z, w_ze, w_ne, w_ve, w_cond, w_take;

    // Flag writes only land while IDLE; during a flush EX holds wrong-path work.
    assign w_idle   = (r_state == S_IDLE);
    assign w_wr_all = ~stall & w_idle & ex_valid & ex_set_all;
    assign w_wr_z   = ~stall & w_idle & ex_valid & ex_set_z & ~ex_set_all;

    assign w_ze = (FWD && (w_wr_all || w_wr_z)) ? alu_z : r_z;
    assign w_ne = (FWD && w_wr_all) ? alu_n : r_n;
    assign w_ve = (FWD && w_wr_all) ? alu_v : r_v;

    always_comb begin
        w_cond = 1'b0;
        case (br_cond)
            3'b000:  w_cond = ~w_ze;
            3'b001:  w_cond = w_ze;
            3'b010:  w_cond = ~w_ze & ~w_ne;
            3'b011:  w_cond = w_ne;
            3'b100:  w_cond = w_ze | (~w_ze & ~w_ne);
            3'b101:  w_cond = w_ne | w_ze;
            3'b110:  w_cond = w_ve;
            default: w_cond = 1'b1;
        endcase
    end

    assign w_take = ~stall & w_idle & br_valid & w_cond;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 3'd0;
            r_z     <= 1'b0;
            r_n     <= 1'b0;
            r_v     <= 1'b0;
            r_taken <= 1'b0;
            r_pc    <= '0;
            r_flush <= 1'b0;
        end else if (!stall) begin
            if (w_wr_all) begin
                r_z <= alu_z;
                r_n <= alu_n;
                r_v <= alu_v;
            end else if (w_wr_z) begin
                r_z <= alu_z;
            end

            if (r_state == S_IDLE) begin
                if (w_take) begin
                    r_taken <= 1'b1;
                    r_pc    <= br_target;
                    r_flush <= 1'b1;
                    r_cnt   <= CNT_INIT;
                    r_state <= S_FLUSH;
                end
            end else begin
                r_taken <= 1'b0;
                if (r_cnt != 3'd0) begin
                    r_cnt <= r_cnt - 3'd1;
                end else begin
                    r_flush <= 1'b0;
                    r_state <= S_IDLE;
                end
            end
        end
    end

    assign z_flag   = r_z;
    assign n_flag   = r_n;
    assign v_flag   = r_v;
    assign br_taken = r_taken;
    assign br_pc    = r_pc;
    assign flush    = r_flush;

endmodule

// File: tb/tb_branch_flag_unit.sv
// tb/tb_branch_flag_unit.sv - randomized and directed bench for branch_flag_unit against a behavioural model
module tb_branch_flag_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        ex_valid = 1'b0, ex_set_all = 1'b0, ex_set_z = 1'b0;
    logic        alu_z = 1'b0, alu_n = 1'b0, alu_v = 1'b0;
    logic        br_valid = 1'b0;
    logic [2:0]  br_cond = 3'd0;
    logic [15:0] br_target = 16'h0;

    logic        z_a, n_a, v_a, tk_a, fl_a;
    logic [15:0] pc_a;
    logic        z_b, n_b, v_b, tk_b, fl_b;
    logic [15:0] pc_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Instance 0: forwarding, 2-cycle flush. Instance 1: register-only flags, 3-cycle flush.
    int          m_len[2] = '{2, 3};
    bit          m_fwd[2] = '{1'b1, 1'b0};
    bit          m_z[2], m_n[2], m_v[2], m_tk[2];
    logic [15:0] m_pc[2];
    int          m_left[2];

    always #5 clk = ~clk;

    branch_flag_unit #(.FLUSH_CYCLES(2), .PC_W(16), .FWD_FLAGS(1)) dut_a (
        .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_set_all(ex_set_all),
        .ex_set_z(ex_set_z), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .br_valid(br_valid),
        .br_cond(br_cond), .br_target(br_target), .z_flag(z_a), .n_flag(n_a), .v_flag(v_a),
        .br_taken(tk_a), .br_pc(pc_a), .flush(fl_a));

    branch_flag_unit #(.FLUSH_CYCLES(3), .PC_W(16), .FWD_FLAGS(0)) dut_b (
        .clk(clk), .rst(rst), .stall(stall), .ex_valid(ex_valid), .ex_set_all(ex_set_all),
        .ex_set_z(ex_set_z), .alu_z(alu_z), .alu_n(alu_n), .alu_v(alu_v), .br_valid(br_valid),
        .br_cond(br_cond), .br_target(br_target), .z_flag(z_b), .n_flag(n_b), .v_flag(v_b),
        .br_taken(tk_b), .br_pc(pc_b), .flush(fl_b));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit cond_true(input logic [2:0] c, input bit z, input bit n, input bit v);
        case (c)
            3'd0: return !z;
            3'd1: return z;
            3'd2: return !z && !n;
            3'd3: return n;
            3'd4: return z || !n;
            3'd5: return n || z;
            3'd6: return v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            m_z[i] = 0; m_n[i] = 0; m_v[i] = 0; m_tk[i] = 0; m_pc[i] = 16'h0; m_left[i] = 0;
        end
    endtask

    task automatic model_step();
        bit nz, nn, nv, wr;
        for (int i = 0; i < 2; i++) begin
            if (stall) continue;
            if (m_left[i] > 0) begin
                m_tk[i] = 0;
                m_left[i]--;
                continue;
            end
            nz = m_z[i]; nn = m_n[i]; nv = m_v[i];
            wr = 0;
            if (ex_valid && ex_set_all) begin
                nz = alu_z; nn = alu_n; nv = alu_v; wr = 1;
            end else if (ex_valid && ex_set_z) begin
                nz = alu_z; wr = 1;
            end
            if (br_valid && (m_fwd[i] && wr ? cond_true(br_cond, nz, nn, nv)
                                            : cond_true(br_cond, m_z[i], m_n[i], m_v[i]))) begin
                m_tk[i] = 1; m_pc[i] = br_target; m_left[i] = m_len[i];
            end
            m_z[i] = nz; m_n[i] = nn; m_v[i] = nv;
        end
    endtask

    task automatic compare_all();
        chk("a_z", z_a, m_z[0]);   chk("a_n", n_a, m_n[0]);   chk("a_v", v_a, m_v[0]);
        chk("a_taken", tk_a, m_tk[0]); chk("a_flush", fl_a, m_left[0] > 0);
        if (m_tk[0]) chk("a_pc", pc_a, m_pc[0]);
        chk("b_z", z_b, m_z[1]);   chk("b_n", n_b, m_n[1]);   chk("b_v", v_b, m_v[1]);
        chk("b_taken", tk_b, m_tk[1]); chk("b_flush", fl_b, m_left[1] > 0);
        if (m_tk[1]) chk("b_pc", pc_b, m_pc[1]);
    endtask

    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        compare_all();
    endtask

    task automatic idle_inputs();
        stall = 0; ex_valid = 0; ex_set_all = 0; ex_set_z = 0;
        alu_z = 0; alu_n = 0; alu_v = 0; br_valid = 0; br_cond = 3'd0; br_target = 16'h0;
    endtask

    task automatic drain();
        idle_inputs();
        for (int i = 0; i < 5; i++) cycle();
    endtask

    task automatic set_flags(input bit z, input bit n, input bit v);
        idle_inputs();
        ex_valid = 1; ex_set_all = 1; alu_z = z; alu_n = n; alu_v = v;
        cycle();
        idle_inputs();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        compare_all();
        chk("reset_flush", fl_a, 1'b0);
        rst = 0;

        // Flag masking
        set_flags(0, 1, 1);
        chk("mask_all_z", z_a, 1'b0); chk("mask_all_n", n_a, 1'b1); chk("mask_all_v", v_a, 1'b1);
        ex_valid = 1; ex_set_z = 1; alu_z = 1; alu_n = 0; alu_v = 0;
        cycle();
        chk("mask_z_z", z_a, 1'b1); chk("mask_z_n", n_a, 1'b1); chk("mask_z_v", v_a, 1'b1);
        ex_valid = 0; ex_set_all = 1; alu_z = 0;
        cycle();
        chk("exv0_z", z_a, 1'b1);

        // Forwarding: instance 0 takes, instance 1 sees register Z=0
        set_flags(0, 0, 0);
        ex_valid = 1; ex_set_all = 1; alu_z = 1; br_valid = 1; br_cond = 3'b001; br_target = 16'h0040;
        cycle();
        chk("fwd_taken", tk_a, 1'b1); chk("fwd_pc", pc_a, 16'h0040); chk("fwd_flush0", fl_a, 1'b1);
        chk("nofwd_taken", tk_b, 1'b0);
        idle_inputs();
        cycle();
        chk("fwd_taken_end", tk_a, 1'b0); chk("fwd_flush1", fl_a, 1'b1);
        cycle();
        chk("fwd_flush_end", fl_a, 1'b0);
        drain();

        // Wrong-path suppression
        set_flags(0, 0, 0);
        br_valid = 1; br_cond = 3'b111; br_target = 16'h1234;
        cycle();
        ex_valid = 1; ex_set_all = 1; alu_z = 1; br_target = 16'h5678;
        cycle();
        chk("wp_taken", tk_a, 1'b0); chk("wp_z", z_a, 1'b0); chk("wp_pc", pc_a, 16'h1234);
        drain();

        // Stall stretches pulse and flush
        br_valid = 1; br_cond = 3'b111; br_target = 16'h00aa;
        cycle();
        idle_inputs(); stall = 1;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("stall_taken", tk_a, 1'b1); chk("stall_flush", fl_a, 1'b1);
        end
        stall = 0;
        cycle();
        chk("rel_taken", tk_a, 1'b0); chk("rel_flush", fl_a, 1'b1);
        cycle();
        chk("rel_flush_end", fl_a, 1'b0);
        drain();

        // Reset mid-flush is asynchronous
        br_valid = 1; br_cond = 3'b111; br_target = 16'hbeef;
        cycle();
        idle_inputs();
        #2 rst = 1;
        #1;
        model_reset();
        chk("arst_taken", tk_a, 1'b0); chk("arst_flush", fl_a, 1'b0); chk("arst_pc", pc_a, 16'h0);
        chk("arst_flush_b", fl_b, 1'b0);
        @(posedge clk); #1;
        compare_all();
        rst = 0;
        drain();

        // Sweep every condition against every flag combination (register path)
        for (int f = 0; f < 8; f++) begin
            for (int c = 0; c < 8; c++) begin
                set_flags(f[2], f[1], f[0]);
                br_valid = 1; br_cond = 3'(c); br_target = 16'(f * 8 + c);
                cycle();
                chk("sweep", tk_a, cond_true(3'(c), f[2], f[1], f[0]));
                drain();
            end
        end

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            stall      = ($urandom_range(0, 5) == 0);
            ex_valid   = $urandom_range(0, 1);
            ex_set_all = $urandom_range(0, 1);
            ex_set_z   = $urandom_range(0, 1);
            alu_z      = $urandom_range(0, 1);
            alu_n      = $urandom_range(0, 1);
            alu_v      = $urandom_range(0, 1);
            br_valid   = ($urandom_range(0, 2) == 0);
            br_cond    = 3'($urandom_range(0, 7));
            br_target  = 16'($urandom);
            cycle();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
